regfile_wb_scoreboard: RTL and testbench
========================================

Name: regfile_wb_scoreboard

Overview:
- Destination side of the register-address path. The decode stage selects a 5-bit destination register address, and this block consumes it.
- It holds the 32-entry general register file and a per-register busy scoreboard.
- Destination addresses are accepted at issue and marked busy. They are cleared when the matching write-back arrives.
- It supplies two read ports to decode with write-back bypass and busy flags, so decode can detect RAW hazards.

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width; matches the 5-bit destination select path.
- NREGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs_addr  input  ADDR_W  read port A address.
- rt_addr  input  ADDR_W  read port B address.
- rs_data  output  DATA_W  read port A data, combinational.
- rt_data  output  DATA_W  read port B data, combinational.
- rs_busy  output  1  port A register has a pending write.
- rt_busy  output  1  port B register has a pending write.
- issue_valid  input  1  decode requests to reserve a destination register.
- issue_addr  input  ADDR_W  destination register address from the destination mux.
- issue_ready  output  1  reservation accepted this cycle.
- wb_valid  input  1  write-back strobe.
- wb_addr  input  ADDR_W  write-back destination.
- wb_data  input  DATA_W  write-back value.
- wb_err  output  1  sticky flag: write-back to a non-busy, non-zero register.

Behaviour:
- Reset (rst_n low, asynchronous): every register and every busy bit goes to 0, and wb_err goes to 0.
  - While in reset, rs_data = rt_data = 0, rs_busy = rt_busy = 0, issue_ready = issue_valid.
  - Reset asserted mid-operation drops all pending reservations. No write-back completes in the cycle reset is sampled low.
- Register 0 is hardwired:
  - Always reads 0 and is never busy.
  - Writes to it are ignored.
  - Issues to it are always ready and set nothing.
  - Write-back to it never sets wb_err.
- Read ports are combinational.
  - If wb_valid is high and wb_addr == read addr != 0, the port returns wb_data (bypass). Its busy flag then reads 0 if that write-back clears the reservation.
  - Otherwise the port returns the stored value and busy[addr].
- issue_ready = !busy[issue_addr] OR (wb_valid AND wb_addr == issue_addr) OR (issue_addr == 0).
  - This is a WAW guard: only one outstanding write per register.
  - Combinational; no dependence on issue_valid.
- Busy bit update at the clock edge:
  - For a handshake (issue_valid and issue_ready) with addr != 0, busy[issue_addr] is set.
  - For wb_valid, busy[wb_addr] is cleared.
  - If both target the same address in one cycle, set wins and busy stays 1 (new reservation after the completing write).
- Register write at the clock edge: if wb_valid and wb_addr != 0, reg[wb_addr] <= wb_data, regardless of the busy state.
- wb_err: set at the clock edge when wb_valid, wb_addr != 0 and busy[wb_addr] == 0 before the edge. Cleared only by reset.
- Latency:
  - Issue to busy visible: next cycle.
  - Write-back to read data: same cycle via bypass, stored from the next cycle.
- Multiple issues per cycle are not supported.
- Multiple write-backs per cycle are not supported.

Test Plan:
1. Reset, then read r0..r31 on both ports -> all data 0, busy 0, wb_err 0. Issue r5 -> issue_ready 1; next cycle rs_addr=5 gives rs_busy 1.
2. With r5 busy, issue r5 again, no write-back -> issue_ready 0 and busy unchanged. Same cycle wb r5=0xDEADBEEF -> issue_ready 1; next cycle busy 1 and rs_data 0xDEADBEEF.
3. Issue r7, then wb r7=0x12345678 while rs_addr=rt_addr=7 -> both ports give 0x12345678 with busy 0 in the wb cycle; next cycle the stored value is 0x12345678 and busy is 0.
4. Issue r0, then wb r0=0xFFFFFFFF -> issue_ready 1; r0 reads 0 and is never busy; wb_err stays 0.
5. wb r9=0x1 with r9 not busy -> r9 reads 1 next cycle and wb_err goes to 1. It stays 1 through further traffic until rst_n is pulsed low.
6. Issue r3 and r4 and write r4=0xAA, then assert rst_n low mid-cycle -> outputs go to zero immediately, without waiting for a clock edge. After release, r3/r4 read 0 and are not busy.

Source files
------------

// File: rtl/regfile_wb_scoreboard.sv
// Destination-side register file: 32 general registers with a per-register busy
// scoreboard, issue-time WAW guard, write-back bypass on both read ports and a sticky wb_err.
module regfile_wb_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_err
);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  busy;
  logic [NREGS-1:0]  busy_next;
  logic              wb_live;
  logic              issue_fire;
  logic              err_set;

  assign wb_live    = wb_valid && (wb_addr != '0);
  assign issue_fire = issue_valid && issue_ready && (issue_addr != '0);
  assign err_set    = wb_live && !busy[wb_addr];

  // Clear from write-back first so a same-cycle re-issue of that register wins.
  always_comb begin
    busy_next = busy;
    if (wb_live)
      busy_next[wb_addr] = 1'b0;
    if (issue_fire)
      busy_next[issue_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs[i] <= '0;
      busy   <= '0;
      wb_err <= 1'b0;
    end else begin
      if (wb_live)
        regs[wb_addr] <= wb_data;
      busy <= busy_next;
      if (err_set)
        wb_err <= 1'b1;
    end
  end

  // Bypassed reads report not-busy: the write-back retires the reservation being read.
  always_comb begin
    rs_data = '0;
    rs_busy = 1'b0;
    if (rst_n && (rs_addr != '0)) begin
      if (wb_valid && (wb_addr == rs_addr)) begin
        rs_data = wb_data;
      end else begin
        rs_data = regs[rs_addr];
        rs_busy = busy[rs_addr];
      end
    end
  end

  always_comb begin
    rt_data = '0;
    rt_busy = 1'b0;
    if (rst_n && (rt_addr != '0)) begin
      if (wb_valid && (wb_addr == rt_addr)) begin
        rt_data = wb_data;
      end else begin
        rt_data = regs[rt_addr];
        rt_busy = busy[rt_addr];
      end
    end
  end

  always_comb begin
    if (!rst_n)
      issue_ready = issue_valid;
    else
      issue_ready = !busy[issue_addr]
                 || (wb_valid && (wb_addr == issue_addr))
                 || (issue_addr == '0);
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed scenarios plus randomized traffic for regfile_wb_scoreboard, checked against
// an array-based model of the register/scoreboard rules.
module tb_regfile_wb_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs_addr, rt_addr, issue_addr, wb_addr;
  logic [31:0] rs_data, rt_data, wb_data;
  logic        rs_busy, rt_busy, issue_valid, issue_ready, wb_valid, wb_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_err;

  always #5 clk = ~clk;

  regfile_wb_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (wb_valid && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    if (wb_valid && wb_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic exp_ready();
    return (issue_addr == 0) || !m_busy[issue_addr] || (wb_valid && wb_addr == issue_addr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_busy = 32'h0;
    m_err  = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rs_data"}, rs_data, exp_data(rs_addr));
    check({tag, ".rt_data"}, rt_data, exp_data(rt_addr));
    check({tag, ".rs_busy"}, {31'h0, rs_busy}, {31'h0, exp_busy(rs_addr)});
    check({tag, ".rt_busy"}, {31'h0, rt_busy}, {31'h0, exp_busy(rt_addr)});
    check({tag, ".issue_ready"}, {31'h0, issue_ready}, {31'h0, exp_ready()});
    check({tag, ".wb_err"}, {31'h0, wb_err}, {31'h0, m_err});
  endtask

  // Inputs already driven; check combinational view, then advance one clock and the model.
  task automatic step(input string tag);
    logic [31:0] nb;
    #1;
    check_outputs(tag);
    nb = m_busy;
    if (wb_valid && wb_addr != 0) begin
      if (!m_busy[wb_addr]) m_err = 1'b1;
      m_regs[wb_addr] = wb_data;
      nb[wb_addr] = 1'b0;
    end
    if (issue_valid && exp_ready() && issue_addr != 0) nb[issue_addr] = 1'b1;
    @(posedge clk);
    m_busy = nb;
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_addr = 5'd0;
    wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic check_in_reset(input string tag);
    check({tag, ".rs_data"}, rs_data, 32'h0);
    check({tag, ".rt_data"}, rt_data, 32'h0);
    check({tag, ".rs_busy"}, {31'h0, rs_busy}, 32'h0);
    check({tag, ".rt_busy"}, {31'h0, rt_busy}, 32'h0);
    check({tag, ".issue_ready"}, {31'h0, issue_ready}, {31'h0, issue_valid});
    check({tag, ".wb_err"}, {31'h0, wb_err}, 32'h0);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    idle();
    rs_addr = 5'd3; rt_addr = 5'd4;
    issue_valid = 1'b1; issue_addr = 5'd6;
    @(posedge clk); #1;
    check_in_reset("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(posedge clk); #1;

    // 1: everything reads zero after reset, then reserve r5.
    for (int i = 0; i < 32; i++) begin
      rs_addr = 5'(i); rt_addr = 5'(31 - i);
      #1;
      check_outputs("t1_scan");
    end
    issue_valid = 1'b1; issue_addr = 5'd5;
    step("t1_issue5");
    idle(); rs_addr = 5'd5; rt_addr = 5'd0;
    #1;
    check("t1_r5_busy", {31'h0, rs_busy}, 32'h1);

    // 2: WAW guard, then same-cycle write-back releases it and the new reservation wins.
    issue_valid = 1'b1; issue_addr = 5'd5;
    step("t2_blocked");
    check("t2_r5_still_busy", {31'h0, rs_busy}, 32'h1);
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEADBEEF;
    #1;
    check("t2_ready_by_wb", {31'h0, issue_ready}, 32'h1);
    step("t2_wb_and_issue");
    idle();
    #1;
    check("t2_busy_again", {31'h0, rs_busy}, 32'h1);
    check("t2_stored", rs_data, 32'hDEADBEEF);

    // 3: bypass on both ports.
    issue_valid = 1'b1; issue_addr = 5'd7;
    step("t3_issue7");
    idle(); rs_addr = 5'd7; rt_addr = 5'd7;
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h12345678;
    #1;
    check("t3_bypass_rs", rs_data, 32'h12345678);
    check("t3_bypass_rt", rt_data, 32'h12345678);
    check("t3_bypass_busy", {30'h0, rs_busy, rt_busy}, 32'h0);
    step("t3_wb7");
    idle();
    #1;
    check("t3_stored", rt_data, 32'h12345678);
    check("t3_free", {30'h0, rs_busy, rt_busy}, 32'h0);

    // 4: r0 is hardwired.
    rs_addr = 5'd0; rt_addr = 5'd0;
    issue_valid = 1'b1; issue_addr = 5'd0;
    #1;
    check("t4_r0_ready", {31'h0, issue_ready}, 32'h1);
    step("t4_issue0");
    idle(); wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    step("t4_wb0");
    idle();
    #1;
    check("t4_r0_zero", rs_data, 32'h0);
    check("t4_no_err", {31'h0, wb_err}, 32'h0);

    // 5: write-back to an idle register raises sticky wb_err.
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'h1;
    step("t5_wb9");
    idle(); rs_addr = 5'd9;
    #1;
    check("t5_r9", rs_data, 32'h1);
    check("t5_err", {31'h0, wb_err}, 32'h1);

    // Randomized traffic; write-backs mostly target busy registers.
    for (int n = 0; n < 400; n++) begin
      rs_addr = 5'($urandom_range(0, 31));
      rt_addr = ($urandom_range(0, 3) == 0) ? rs_addr : 5'($urandom_range(0, 31));
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = 5'($urandom_range(0, 31));
      wb_valid    = 1'($urandom_range(0, 1));
      wb_addr     = 5'($urandom_range(0, 31));
      for (int k = 0; k < 8 && !m_busy[wb_addr] && m_busy != 0; k++)
        wb_addr = 5'($urandom_range(1, 31));
      if ($urandom_range(0, 3) == 0) rs_addr = wb_addr;
      if ($urandom_range(0, 5) == 0) issue_addr = wb_addr;
      wb_data = $urandom;
      step("rand");
    end

    // 6: asynchronous reset drops reservations and stored data.
    idle(); issue_valid = 1'b1; issue_addr = 5'd3;
    step("t6_issue3");
    issue_addr = 5'd4;
    step("t6_issue4");
    idle(); wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'hAA;
    rs_addr = 5'd3; rt_addr = 5'd4;
    step("t6_wb4");
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h55; issue_valid = 1'b1; issue_addr = 5'd3;
    #3;
    rst_n = 1'b0;
    #1;
    check_in_reset("t6_async");
    model_reset();
    @(posedge clk); #1;
    check_in_reset("t6_held");
    @(negedge clk);
    rst_n = 1'b1;
    idle(); rs_addr = 5'd3; rt_addr = 5'd4;
    @(posedge clk); #1;
    check_outputs("t6_after");
    check("t6_r4_zero", rt_data, 32'h0);
    check("t6_r3_free", {31'h0, rs_busy}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
